// File: rtl/dmux_4way.sv
// 1-to-4 demultiplexer: routes 'in' to one of a/b/c/d by 'sel', zeroing the rest.
// Optional output register (REGISTERED=1) with asynchronous active-low clear.
module dmux_4way #(
  parameter int unsigned WIDTH      = 1,
  parameter bit          REGISTERED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d
);

  logic [WIDTH-1:0] lo, hi;
  logic [WIDTH-1:0] a_d, b_d, c_d, d_d;

  // Two levels of 1-to-2 demux: sel[1] picks the a/b or c/d pair, sel[0] picks within it.
  always_comb begin
    lo  = sel[1] ? '0 : in;
    hi  = sel[1] ? in : '0;
    a_d = sel[0] ? '0 : lo;
    b_d = sel[0] ? lo : '0;
    c_d = sel[0] ? '0 : hi;
    d_d = sel[0] ? hi : '0;
  end

  if (REGISTERED) begin : g_reg
    logic [WIDTH-1:0] a_q, b_q, c_q, d_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q <= '0;
        b_q <= '0;
        c_q <= '0;
        d_q <= '0;
      end else begin
        a_q <= a_d;
        b_q <= b_d;
        c_q <= c_d;
        d_q <= d_d;
      end
    end

    assign a = a_q;
    assign b = b_q;
    assign c = c_q;
    assign d = d_q;
  end else begin : g_comb
    // Clock and reset have no function in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign a = a_d;
    assign b = b_d;
    assign c = c_d;
    assign d = d_d;
  end

endmodule

// File: tb/tb_dmux_4way.sv
// Randomized self-checking bench for dmux_4way: combinational 1-bit and 8-bit builds
// plus the registered 8-bit build, against a shift-based reference model.
module tb_dmux_4way;

  logic       clk;
  logic       rst_n;
  logic       in1;
  logic [7:0] in8;
  logic [1:0] sel;

  logic       a1, b1, c1, d1;
  logic [7:0] a8, b8, c8, d8;
  logic [7:0] ar, br, cr, dr;

  int n_checks = 0;
  int n_errors = 0;

  dmux_4way #(.WIDTH(1), .REGISTERED(1'b0)) u_comb1 (
    .clk(clk), .rst_n(rst_n), .in(in1), .sel(sel), .a(a1), .b(b1), .c(c1), .d(d1)
  );

  dmux_4way #(.WIDTH(8), .REGISTERED(1'b0)) u_comb8 (
    .clk(clk), .rst_n(rst_n), .in(in8), .sel(sel), .a(a8), .b(b8), .c(c8), .d(d8)
  );

  dmux_4way #(.WIDTH(8), .REGISTERED(1'b1)) u_reg8 (
    .clk(clk), .rst_n(rst_n), .in(in8), .sel(sel), .a(ar), .b(br), .c(cr), .d(dr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: output vector {d,c,b,a} is the input shifted into the selected lane.
  function automatic logic [31:0] model1(input logic din, input logic [1:0] s);
    return 32'(din) << s;
  endfunction

  function automatic logic [31:0] model8(input logic [7:0] din, input logic [1:0] s);
    return 32'(din) << (8 * int'(s));
  endfunction

  function automatic logic [31:0] vec1();
    return {28'h0, d1, c1, b1, a1};
  endfunction

  function automatic logic [31:0] vec8();
    return {d8, c8, b8, a8};
  endfunction

  function automatic logic [31:0] vecr();
    return {dr, cr, br, ar};
  endfunction

  logic [31:0] reg_exp;

  initial begin
    rst_n = 1'b0;
    in1   = 1'b1;
    in8   = 8'h00;
    sel   = 2'b00;

    // Combinational builds ignore reset; registered build is held at zero.
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      in1 = 1'b1;
      #1;
      check($sformatf("comb1_in1_sel%0d", s), vec1(), model1(1'b1, 2'(s)));
      in1 = 1'b0;
      #1;
      check($sformatf("comb1_in0_sel%0d", s), vec1(), 32'h0);
    end
    in8 = 8'hA5;
    sel = 2'b10;
    #1;
    check("comb8_a5_sel2", vec8(), 32'h00A5_0000);
    check("reg_reset_no_edge", vecr(), 32'h0);

    @(posedge clk);
    #1;
    check("reg_reset_over_edge", vecr(), 32'h0);

    // Release reset; first capture only on the next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    in8   = 8'h3C;
    sel   = 2'b11;
    #1;
    check("reg_before_first_edge", vecr(), 32'h0);
    @(posedge clk);
    #1;
    check("reg_first_capture", vecr(), 32'h3C00_0000);

    // Randomized traffic; inputs move on the falling edge.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      in1 = 1'($urandom);
      in8 = 8'($urandom);
      sel = 2'($urandom_range(0, 3));
      reg_exp = model8(in8, sel);
      #1;
      check("rand_comb1", vec1(), model1(in1, sel));
      check("rand_comb8", vec8(), model8(in8, sel));
      @(posedge clk);
      #1;
      check("rand_reg8", vecr(), reg_exp);
    end

    // Async reset pulse between edges clears outputs at once.
    @(negedge clk);
    in8 = 8'h81;
    sel = 2'b01;
    @(posedge clk);
    #1;
    check("reg_pre_pulse", vecr(), 32'h0000_8100);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("reg_async_clear", vecr(), 32'h0);
    rst_n = 1'b1;
    #1;
    check("reg_hold_after_release", vecr(), 32'h0);
    @(posedge clk);
    #1;
    check("reg_recapture", vecr(), 32'h0000_8100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
